prog_loader: RTL

Program loader and instruction store that sits directly upstream of the stack CPU. It accepts a program over a valid/ready word stream and writes it into an internal instruction RAM. It holds the CPU in reset until the last word is accepted, then releases it. While the CPU runs, it serves `instruction = mem[pc]` with one-cycle latency and watches the CPU's `halt`/`error` outputs to end the run.

---
 rtl/prog_loader_pkg.sv | 20 ++
 rtl/prog_ram.sv | 29 ++
 rtl/prog_loader.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the stack CPU program loader.
// Holds the loader state encoding used by prog_loader.
//   loader_state_t : IDLE, LOAD, RUN, DONE, FAULT
package stackCPU_DEFS;

  // state | meaning
  // IDLE  | after reset, CPU held in reset, waiting for load_start
  // LOAD  | accepting program words into the instruction RAM
  // RUN   | CPU released, serving instructions, watching halt/error
  // DONE  | run ended via halt/error, CPU left running so result is visible
  // FAULT | load overflow or watchdog timeout, CPU held in reset
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    DONE  = 3'd3,
    FAULT = 3'd4
  } loader_state_t;

endpackage

// File: rtl/prog_ram.sv
// Instruction RAM: one write port, one synchronous read port, DEPTH x WIDTH.
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address, sampled on the rising edge
//   rdata  out  read data, valid one cycle after raddr is sampled
module prog_ram #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/prog_loader.sv
// Program loader and instruction store in front of the stack CPU.
// Loads a program over a valid/ready stream into prog_ram, holds the CPU in
// reset until the last word is accepted, then serves instruction = mem[pc]
// with one-cycle latency and ends the run on halt/error.
// Optional build macro: PROG_LOADER_WATCHDOG_EN adds a RUN-cycle watchdog
// that forces FAULT after WATCHDOG_LIMIT cycles without halt/error.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   load_start            one-cycle request to begin a new load
//   load_valid/ready      word handshake; load_data word, load_last final word
//   pc / instruction      CPU fetch address in, instruction out (1-cycle latency)
//   cpu_reset             active-high reset to the CPU
//   halt, error           CPU run-end indications
//   load_count            number of words loaded
//   run_done              run ended via halt or error
//   fault                 load overflow or watchdog timeout
module prog_loader
  import stackCPU_DEFS::*;
#(
  parameter int                     INSTR_WIDTH    = 10,
  parameter int                     PC_WIDTH       = 10,
  parameter int                     MEM_DEPTH      = 1024,
  parameter logic [INSTR_WIDTH-1:0] FILL_WORD      = '0,
  parameter int                     WATCHDOG_LIMIT = 4096
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_start,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [INSTR_WIDTH-1:0] load_data,
  input  logic                   load_last,
  input  logic [PC_WIDTH-1:0]    pc,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   cpu_reset,
  input  logic                   halt,
  input  logic                   error,
  output logic [PC_WIDTH:0]      load_count,
  output logic                   run_done,
  output logic                   fault
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CW = PC_WIDTH + 1;
  localparam logic [AW-1:0] WPTR_LAST = AW'(MEM_DEPTH - 1);

  loader_state_t state, state_nxt;
  logic [AW-1:0] wptr;
  logic          accept;
  logic          wd_tc;
  logic          start_load;
  logic [INSTR_WIDTH-1:0] ram_rdata;
  logic          in_range_q;
  logic          hold_zero_q;

  assign load_ready = (state == LOAD);
  assign accept     = load_valid & load_ready;
  assign start_load = (state_nxt == LOAD) && (state != LOAD);

`ifdef PROG_LOADER_WATCHDOG_EN
  localparam int WDW = $clog2(WATCHDOG_LIMIT + 1);
  logic [WDW-1:0] wd_cnt;

  // Down-counter preloaded on every non-RUN cycle, so it starts fresh on RUN entry;
  // terminal count lands exactly WATCHDOG_LIMIT RUN edges later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              wd_cnt <= '0;
    else if (state != RUN)  wd_cnt <= WDW'(WATCHDOG_LIMIT - 1);
    else if (!wd_tc)        wd_cnt <= wd_cnt - WDW'(1);
  end

  assign wd_tc = (wd_cnt == '0);
`else
  // No watchdog: never reaches terminal count.
  assign wd_tc = (WATCHDOG_LIMIT < 0);
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, FAULT: if (load_start) state_nxt = LOAD;
      LOAD: begin
        if (accept) begin
          if (load_last)               state_nxt = RUN;
          else if (wptr == WPTR_LAST)  state_nxt = FAULT;
        end
      end
      RUN: begin
        // halt/error takes priority over a simultaneous watchdog expiry
        if (halt || error) state_nxt = DONE;
        else if (wd_tc)    state_nxt = FAULT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cpu_reset  <= 1'b1;
      wptr       <= '0;
      load_count <= '0;
      run_done   <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state <= state_nxt;
      // cpu_reset is a dedicated flop of the next-state decode so it never glitches.
      cpu_reset <= !((state_nxt == RUN) || (state_nxt == DONE));
      if (state == IDLE || start_load) begin
        wptr       <= '0;
        load_count <= '0;
        run_done   <= 1'b0;
        fault      <= 1'b0;
      end else begin
        if (accept) begin
          wptr       <= wptr + AW'(1);
          load_count <= load_count + CW'(1);
        end
        if (state == RUN && state_nxt == DONE)    run_done <= 1'b1;
        if (state != FAULT && state_nxt == FAULT) fault    <= 1'b1;
      end
    end
  end

  prog_ram #(
    .WIDTH (INSTR_WIDTH),
    .DEPTH (MEM_DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (accept),
    .waddr (wptr),
    .wdata (load_data),
    .raddr (pc[AW-1:0]),
    .rdata (ram_rdata)
  );

  // The range compare is registered alongside the RAM read so the mux select
  // lines up with the data; hold_zero_q forces instruction to 0 out of reset
  // since the RAM output register itself is not reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_range_q  <= 1'b0;
      hold_zero_q <= 1'b1;
    end else begin
      in_range_q  <= ({1'b0, pc} < load_count);
      hold_zero_q <= 1'b0;
    end
  end

  assign instruction = hold_zero_q ? '0 : (in_range_q ? ram_rdata : FILL_WORD);

endmodule
